// File: rtl/simon_out_sched.sv
// -----------------------------------------------------------------------------
// simon_out_sched
//
// Output scheduler for the SIMON core. Up to four cipher result sources share
// the single SIMON_dataOUT packetiser. The scheduler arbitrates among the ready
// results, latches the winner's two-word block and info byte, and presents
// them together with a packet sequence count. It then holds the packetiser
// until that block has been read and the packet has been emitted.
//
// Parameters
//   N     cipher word width (default `N from the SIMON definitions; 16 if unset)
//   NREQ  number of requesters, legal range 2..4
//
// Ports
//   clk       in   system clock, rising edge
//   nR        in   synchronous active-low reset
//   reqDATA   in   [NREQ]       level request per requester
//   reqINFO   in   [NREQ*8]     info byte per requester
//   reqWORD   in   [NREQ*2*N]   result block per requester
//   ackDATA   out  [NREQ]       one-cycle grant pulse (block/info latched)
//   doneDATA  out  1            block valid to packetiser
//   outDATA   out  [2*N]       latched block
//   infoOUT   out  [8]         latched info byte
//   countOUT  out  [8]         sequence number of the presented packet
//   readDATA  in   1            packetiser has taken the block
//   donePKT   in   1            packetiser has finished the packet
//
// Configuration
//   SIMON_OUT_FIXPRIO_EN  defined: fixed priority, lowest index wins, no
//                         round-robin pointer. Undefined (default): round-robin.
//
// All outputs are registered; no combinational input-to-output paths.
// -----------------------------------------------------------------------------
`ifndef N
`define N 16
`endif

module simon_out_sched #(
    parameter int N    = `N,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic [NREQ-1:0]       reqDATA,
    input  logic [NREQ*8-1:0]     reqINFO,
    input  logic [NREQ*2*N-1:0]   reqWORD,
    output logic [NREQ-1:0]       ackDATA,
    output logic                  doneDATA,
    output logic [2*N-1:0]        outDATA,
    output logic [7:0]            infoOUT,
    output logic [7:0]            countOUT,
    input  logic                  readDATA,
    input  logic                  donePKT
);

    // Requester index width; one spare bit is used for the modular add.
    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        DRAIN
    } state_t;

    state_t            state, state_nx;

    logic [PW-1:0]     rr;          // arbitration start index
    logic              found;       // some request is high
    logic [PW-1:0]     pick;        // arbitration winner this cycle
    logic              grant;       // winner is being latched at this edge
    logic              pkt_end;     // packet completes at this edge

    logic [NREQ-1:0]   ack_nx;
    logic              done_nx;
    logic [2*N-1:0]    out_nx;
    logic [7:0]        info_nx;
    logic [7:0]        cnt_nx;

    // -------------------------------------------------------------------------
    // Arbitration: search begins at rr and wraps; first high request wins.
    // The candidate index is formed with one extra bit so the wrap is correct
    // for non-power-of-two NREQ.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [SW-1:0] sum;
        logic [PW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!found && reqDATA[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        ack_nx   = '0;
        done_nx  = doneDATA;
        out_nx   = outDATA;
        info_nx  = infoOUT;
        cnt_nx   = countOUT;
        grant    = 1'b0;
        pkt_end  = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant        = 1'b1;
                    ack_nx[pick] = 1'b1;
                    done_nx      = 1'b1;
                    out_nx       = reqWORD[int'(pick) * (2*N) +: 2*N];
                    info_nx      = reqINFO[int'(pick) * 8 +: 8];
                    state_nx     = PRESENT;
                end
            end
            PRESENT: begin
                if (readDATA) begin
                    done_nx = 1'b0;
                    // Read and packet-done together skip DRAIN entirely.
                    if (donePKT) begin
                        pkt_end  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (donePKT) begin
                    pkt_end  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                done_nx  = 1'b0;
            end
        endcase

        if (pkt_end) begin
            cnt_nx = countOUT + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            state    <= IDLE;
            ackDATA  <= '0;
            doneDATA <= 1'b0;
            outDATA  <= '0;
            infoOUT  <= '0;
            countOUT <= '0;
        end else begin
            state    <= state_nx;
            ackDATA  <= ack_nx;
            doneDATA <= done_nx;
            outDATA  <= out_nx;
            infoOUT  <= info_nx;
            countOUT <= cnt_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer. After a completed packet the search restarts just
    // past the requester that owned it, so a continuously requesting source
    // cannot starve the others.
    // -------------------------------------------------------------------------
`ifdef SIMON_OUT_FIXPRIO_EN
    assign rr = '0;
`else
    logic [PW-1:0] win;    // owner of the packet in flight
    logic [PW-1:0] rr_nx;
    logic [PW-1:0] win_nx;

    always_comb begin
        win_nx = win;
        rr_nx  = rr;
        if (grant) begin
            win_nx = pick;
        end
        if (pkt_end) begin
            rr_nx = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            rr  <= '0;
            win <= '0;
        end else begin
            rr  <= rr_nx;
            win <= win_nx;
        end
    end
`endif

endmodule

// File: tb/tb_simon_out_sched.sv
// -----------------------------------------------------------------------------
// tb_simon_out_sched
//
// Bench for simon_out_sched with N=16, NREQ=2. Directed stimulus pushes the
// expected grant (requester, block, info, count) into a queue; a monitor pops
// and compares whenever ackDATA pulses.
// -----------------------------------------------------------------------------
module tb_simon_out_sched;

    localparam int N    = 16;
    localparam int NREQ = 2;

    logic                 clk;
    logic                 nR;
    logic [NREQ-1:0]      reqDATA;
    logic [NREQ*8-1:0]    reqINFO;
    logic [NREQ*2*N-1:0]  reqWORD;
    logic [NREQ-1:0]      ackDATA;
    logic                 doneDATA;
    logic [2*N-1:0]       outDATA;
    logic [7:0]           infoOUT;
    logic [7:0]           countOUT;
    logic                 readDATA;
    logic                 donePKT;

    simon_out_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk      (clk),
        .nR       (nR),
        .reqDATA  (reqDATA),
        .reqINFO  (reqINFO),
        .reqWORD  (reqWORD),
        .ackDATA  (ackDATA),
        .doneDATA (doneDATA),
        .outDATA  (outDATA),
        .infoOUT  (infoOUT),
        .countOUT (countOUT),
        .readDATA (readDATA),
        .donePKT  (donePKT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] WORD0 = {16'h6565, 16'h6877};
    localparam logic [31:0] WORD1 = 32'hDEAD_BEEF;
    localparam logic [7:0]  INFO0 = 8'h11;
    localparam logic [7:0]  INFO1 = 8'h22;

    typedef struct {
        int          idx;
        logic [31:0] word;
        logic [7:0]  info;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] cnt);
        exp_t e;
        e.idx  = idx;
        e.word = (idx == 0) ? WORD0 : WORD1;
        e.info = (idx == 0) ? INFO0 : INFO1;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Monitor: every ack pulse must correspond to an expected grant.
    always @(negedge clk) begin
        if (ackDATA !== '0) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(ackDATA), 32'd0);
            end else begin
                exp_t e;
                logic [NREQ-1:0] ea;
                e  = sb.pop_front();
                ea = '0;
                ea[e.idx] = 1'b1;
                chk("ack",      32'(ackDATA),  32'(ea));
                chk("outDATA",  outDATA,       e.word);
                chk("infoOUT",  32'(infoOUT),  32'(e.info));
                chk("countOUT", 32'(countOUT), 32'(e.cnt));
                chk("doneDATA", 32'(doneDATA), 32'd1);
            end
        end
    end

    // Wait for an ack pulse; cycles is the number of edges waited (0 = timeout).
    task automatic grant_wait(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ackDATA != '0) begin
                cycles = i;
                return;
            end
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    // Drive readDATA at edge +rd and donePKT at edge +pk after the grant
    // (0 = not driven); checks doneDATA after each edge and the count at the end.
    task automatic packet(input int rd, input int pk);
        int last;
        last = (rd > pk) ? rd : pk;
        for (int c = 1; c <= last; c++) begin
            readDATA = (c == rd);
            donePKT  = (c == pk);
            @(posedge clk);
            #1;
            chk("done_level", 32'(doneDATA), (rd == 0 || c < rd) ? 32'd1 : 32'd0);
            if (pk != 0 && c < pk) begin
                chk("count_hold", 32'(countOUT), 32'(exp_cnt));
            end
        end
        readDATA = 1'b0;
        donePKT  = 1'b0;
        if (pk != 0) begin
            exp_cnt = exp_cnt + 8'd1;
            chk("count_after", 32'(countOUT), 32'(exp_cnt));
        end
    endtask

    task automatic do_reset(input logic [NREQ-1:0] req);
        nR       = 1'b0;
        reqDATA  = req;
        readDATA = 1'b0;
        donePKT  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_cnt = '0;
        chk("rst_ack",   32'(ackDATA),  32'd0);
        chk("rst_done",  32'(doneDATA), 32'd0);
        chk("rst_out",   outDATA,       32'd0);
        chk("rst_info",  32'(infoOUT),  32'd0);
        chk("rst_count", 32'(countOUT), 32'd0);
    endtask

    int cyc;
    int rr_seq[4];

    initial begin
`ifdef SIMON_OUT_FIXPRIO_EN
        rr_seq = '{0, 0, 0, 0};
`else
        rr_seq = '{0, 1, 0, 1};
`endif
        nR       = 1'b0;
        reqDATA  = '0;
        readDATA = 1'b0;
        donePKT  = 1'b0;
        reqWORD  = {WORD1, WORD0};
        reqINFO  = {INFO1, INFO0};
        @(posedge clk);
        #1;

        // Reset with all requests high.
        do_reset(2'b11);

        // Single requester.
        reqDATA = 2'b01;
        push(0, 8'd0);
        nR = 1'b1;
        grant_wait(cyc);
        chk("single_latency", 32'(cyc), 32'd1);
        reqDATA = 2'b00;
        packet(3, 5);

        // Both requesters held high for four packets.
        do_reset(2'b00);
        reqDATA = 2'b11;
        nR = 1'b1;
        for (int p = 0; p < 4; p++) begin
            push(rr_seq[p], 8'(p));
            grant_wait(cyc);
            if (p == 3) reqDATA = 2'b00;
            packet(2, 3);
        end
        chk("rr_final_count", 32'(countOUT), 32'd4);

        // Collapsed read/done and counter wrap over 256 packets.
        do_reset(2'b00);
        reqDATA = 2'b01;
        nR = 1'b1;
        for (int k = 0; k < 256; k++) begin
            push(0, 8'(k));
            grant_wait(cyc);
            if (k > 0) chk("collapse_gap", 32'(cyc), 32'd1);
            if (k == 255) reqDATA = 2'b00;
            packet(1, 1);
        end
        chk("wrap_count", 32'(countOUT), 32'd0);

        // Reset during DRAIN, then stray handshakes in IDLE.
        do_reset(2'b00);
        reqDATA = 2'b10;
        nR = 1'b1;
        push(1, 8'd0);
        grant_wait(cyc);
        reqDATA = 2'b00;
        packet(1, 0);
        nR = 1'b0;
        @(posedge clk);
        #1;
        nR = 1'b1;
        chk("mid_rst_done",  32'(doneDATA), 32'd0);
        chk("mid_rst_count", 32'(countOUT), 32'd0);
        chk("mid_rst_out",   outDATA,       32'd0);
        readDATA = 1'b1;
        @(posedge clk);
        #1;
        readDATA = 1'b0;
        donePKT  = 1'b1;
        @(posedge clk);
        #1;
        donePKT = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_count", 32'(countOUT), 32'd0);
        chk("stray_done",  32'(doneDATA), 32'd0);
        chk("stray_ack",   32'(ackDATA),  32'd0);

        // Pointer restarts at 0 after reset.
        reqDATA = 2'b11;
        push(0, 8'd0);
        grant_wait(cyc);
        reqDATA = 2'b00;
        packet(1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
